// File: rtl/conexao_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conexao_pkg
// Description : Shared definitions for the sensor-connection response path:
//               serialiser state codes, default bit timing and the response
//               command byte values.
// Revision    : 1.0 - initial release
// ============================================================================
package conexao_pkg;

    // 50 MHz system clock, 9600 baud
    localparam int unsigned c_DEFAULT_CLKS_PER_BIT = 5208;

    // State codes shared by the response sequencer and the byte serialiser
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_GAP   = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    // Response command bytes
    localparam logic [7:0] c_CMD_OK          = 8'h07;
    localparam logic [7:0] c_CMD_UMIDADE     = 8'h08;
    localparam logic [7:0] c_CMD_TEMPERATURA = 8'h09;
    localparam logic [7:0] c_CMD_FALHA       = 8'h1F;
    localparam logic [7:0] c_CMD_ERRO        = 8'h45;
    localparam logic [7:0] c_CMD_INVALIDO_A  = 8'hAA;
    localparam logic [7:0] c_CMD_INVALIDO_F  = 8'hFF;

    // True for command bytes that are not one of the two invalid markers
    function automatic logic cmd_is_valid(input logic [7:0] cmd);
        return (cmd != c_CMD_INVALIDO_A) && (cmd != c_CMD_INVALIDO_F);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_envio_resposta_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_envio_resposta_if
// Description : Response hand-off from the sensor-connection block plus the
//               UART line and status flags of the response transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_envio_resposta_if;

    logic       dados_validos;
    logic [7:0] resp_command;
    logic [7:0] resp_value;
    logic       tx;
    logic       ocupado;
    logic       envio_concluido;
    logic       overflow;

    // Producer side: offers response pairs, watches the transmitter
    modport master (
        output dados_validos,
        output resp_command,
        output resp_value,
        input  tx,
        input  ocupado,
        input  envio_concluido,
        input  overflow
    );

    // Transmitter side
    modport slave (
        input  dados_validos,
        input  resp_command,
        input  resp_value,
        output tx,
        output ocupado,
        output envio_concluido,
        output overflow
    );

endinterface
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : Serialises one byte as an 8N1 frame, LSB first. A new byte
//               may be started in the last stop-bit cycle (o_done high) so
//               consecutive frames are emitted back to back with no gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import conexao_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT
)(
    input  wire        clock,
    input  wire        reset,
    input  wire        i_start,
    input  wire  [7:0] i_data,
    output logic       o_tx,
    output logic       o_done
);

    localparam int unsigned     c_CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic w_bit_end;

    assign w_bit_end = (r_cnt == c_LAST);
    assign o_done    = (r_state == c_ST_STOP) && w_bit_end;
    assign o_tx      = r_tx;

    // Frame sequencer; the baud counter restarts on every state entry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (i_start) begin
                        r_shift <= i_data;
                        r_tx    <= 1'b0;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_STOP;
                        end else begin
                            // next bit sits at position 1 before the shift lands
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (i_start) begin
                            r_shift <= i_data;
                            r_tx    <= 1'b0;
                            r_state <= c_ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_envio_resposta.sv
`default_nettype none
// ============================================================================
// Module      : uart_envio_resposta
// Description : Sends each {command, value} response as two 8N1 frames
//               (command first). One pending slot queues a response that
//               arrives mid-transfer; a further one is dropped and flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_envio_resposta
    import conexao_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned GAP_BITS     = 0
)(
    input  wire                   clock,
    input  wire                   reset,
    uart_envio_resposta_if.slave  bus
);

    localparam logic [31:0] c_GAP_LAST = (GAP_BITS > 0) ? 32'(GAP_BITS * CLKS_PER_BIT - 1) : 32'd0;

    logic [2:0]  r_state;
    logic        r_byte_sel;
    logic [7:0]  r_act_val;
    logic [7:0]  r_pend_cmd;
    logic [7:0]  r_pend_val;
    logic        r_pend_full;
    logic [31:0] r_gap_cnt;
    logic        r_ocupado;
    logic        r_envio;
    logic        r_overflow;

    logic       w_tx;
    logic       w_byte_done;
    logic       w_boundary;
    logic       w_from_pend;
    logic       w_from_input;
    logic       w_new_pair;
    logic       w_second_byte;
    logic       w_ser_start;
    logic [7:0] w_ser_data;
    logic [7:0] w_next_val;
    logic       w_to_pend;
    logic       w_drop;

    // IDLE and DONE are the only points where a new pair may become active;
    // the pending slot always has priority over a fresh pulse there.
    assign w_boundary    = (r_state == c_ST_IDLE) || (r_state == c_ST_DONE);
    assign w_from_pend   = w_boundary && r_pend_full;
    assign w_from_input  = w_boundary && !r_pend_full && bus.dados_validos;
    assign w_new_pair    = w_from_pend || w_from_input;
    assign w_second_byte = (r_state == c_ST_START) && w_byte_done && !r_byte_sel;
    assign w_ser_start   = w_new_pair || w_second_byte;
    assign w_ser_data    = w_second_byte ? r_act_val
                         : (w_from_pend ? r_pend_cmd : bus.resp_command);
    assign w_next_val    = w_from_pend ? r_pend_val : bus.resp_value;

    // A pulse that does not go straight to active fills the pending slot if
    // it is free or is being emptied this very cycle; otherwise it is lost.
    assign w_to_pend = bus.dados_validos && !w_from_input && (!r_pend_full || w_from_pend);
    assign w_drop    = bus.dados_validos && !w_from_input && r_pend_full && !w_from_pend;

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clock   (clock),
        .reset   (reset),
        .i_start (w_ser_start),
        .i_data  (w_ser_data),
        .o_tx    (w_tx),
        .o_done  (w_byte_done)
    );

    assign bus.tx              = w_tx;
    assign bus.ocupado         = r_ocupado;
    assign bus.envio_concluido = r_envio;
    assign bus.overflow        = r_overflow;

    // One-entry pending buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend_full <= 1'b0;
            r_pend_cmd  <= '0;
            r_pend_val  <= '0;
        end else if (w_to_pend) begin
            r_pend_full <= 1'b1;
            r_pend_cmd  <= bus.resp_command;
            r_pend_val  <= bus.resp_value;
        end else if (w_from_pend) begin
            r_pend_full <= 1'b0;
        end
    end

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Response sequencer: command frame, value frame, optional gap, DONE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_byte_sel <= 1'b0;
            r_act_val  <= '0;
            r_gap_cnt  <= '0;
            r_ocupado  <= 1'b0;
            r_envio    <= 1'b0;
        end else begin
            r_envio <= 1'b0;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    r_byte_sel <= 1'b0;
                    r_ocupado  <= w_new_pair;
                    if (w_new_pair) begin
                        r_act_val <= w_next_val;
                        r_state   <= c_ST_START;
                    end else begin
                        r_state   <= c_ST_IDLE;
                    end
                end
                c_ST_START: begin
                    // both frames run inside the serialiser; here we only
                    // track which byte is on the line
                    r_ocupado <= 1'b1;
                    if (w_byte_done) begin
                        if (!r_byte_sel) begin
                            r_byte_sel <= 1'b1;
                        end else begin
                            r_gap_cnt <= '0;
                            if (GAP_BITS > 0) begin
                                r_state <= c_ST_GAP;
                            end else begin
                                r_state <= c_ST_DONE;
                                r_envio <= 1'b1;
                            end
                        end
                    end
                end
                c_ST_GAP: begin
                    r_ocupado <= 1'b1;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= c_ST_DONE;
                        r_envio <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_ocupado <= r_pend_full;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_envio_resposta.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_envio_resposta
// Description : Drives two transmitters (no gap, two-bit gap) with the same
//               directed and random response pulses and compares every
//               output, every cycle, against a timeline model of the frames.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_envio_resposta;
    import conexao_pkg::*;

    localparam int CPB   = 4;
    localparam int FRAME = 20 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dv;
    logic [7:0] cmd;
    logic [7:0] val;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_envio_resposta_if bus0 ();
    uart_envio_resposta_if bus1 ();

    assign bus0.dados_validos = dv;
    assign bus0.resp_command  = cmd;
    assign bus0.resp_value    = val;
    assign bus1.dados_validos = dv;
    assign bus1.resp_command  = cmd;
    assign bus1.resp_value    = val;

    uart_envio_resposta #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
        .clock (clk), .reset (rst_n), .bus (bus0)
    );
    uart_envio_resposta #(.CLKS_PER_BIT(CPB), .GAP_BITS(2)) dut1 (
        .clock (clk), .reset (rst_n), .bus (bus1)
    );

    // Each accepted response: pulse edge, start-bit edge, DONE edge, bytes
    typedef struct {
        int         p;
        int         s;
        int         d;
        logic [7:0] c;
        logic [7:0] v;
    } item_t;

    item_t it    [2][256];
    int    n_it  [2];
    logic  ovf_m [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            n_it[k]  = 0;
            ovf_m[k] = 1'b0;
        end
    endtask

    // A response is freed at DONE+1; at most two may be unfinished
    task automatic model_pulse(input int k, input int p, input logic [7:0] c, input logic [7:0] v);
        int busy;
        int s;
        int n;
        busy = 0;
        n    = n_it[k];
        for (int i = 0; i < n; i++)
            if (it[k][i].d + 1 > p) busy++;
        if (busy >= 2) begin
            ovf_m[k] = 1'b1;
        end else begin
            s = p;
            if (n > 0 && it[k][n-1].d + 1 > p) s = it[k][n-1].d + 1;
            it[k][n].p = p;
            it[k][n].s = s;
            it[k][n].d = s + FRAME + gap_of(k) * CPB;
            it[k][n].c = c;
            it[k][n].v = v;
            n_it[k]    = n + 1;
        end
    endtask

    function automatic logic exp_tx(input int k, input int e);
        int         b;
        int         idx;
        logic [7:0] byte_v;
        for (int i = 0; i < n_it[k]; i++) begin
            if (e >= it[k][i].s && e < it[k][i].s + FRAME) begin
                b      = (e - it[k][i].s) / CPB;
                idx    = b % 10;
                byte_v = (b < 10) ? it[k][i].c : it[k][i].v;
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return byte_v[idx-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_oc(input int k, input int e);
        for (int i = 0; i < n_it[k]; i++)
            if (it[k][i].p <= e && it[k][i].d + 1 > e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(input int k, input int e);
        for (int i = 0; i < n_it[k]; i++)
            if (it[k][i].d == e) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        check("tx_g0",   bus0.tx,              exp_tx(0, cyc));
        check("oc_g0",   bus0.ocupado,         exp_oc(0, cyc));
        check("done_g0", bus0.envio_concluido, exp_done(0, cyc));
        check("ovf_g0",  bus0.overflow,        ovf_m[0]);
        check("tx_g2",   bus1.tx,              exp_tx(1, cyc));
        check("oc_g2",   bus1.ocupado,         exp_oc(1, cyc));
        check("done_g2", bus1.envio_concluido, exp_done(1, cyc));
        check("ovf_g2",  bus1.overflow,        ovf_m[1]);
    endtask

    // One clock: present inputs, take the edge, update model, compare
    task automatic step(input logic pulse, input logic [7:0] c, input logic [7:0] v);
        dv  = pulse;
        cmd = c;
        val = v;
        @(posedge clk);
        cyc++;
        if (pulse && rst_n)
            for (int k = 0; k < 2; k++) model_pulse(k, cyc, c, v);
        #1;
        check_all();
        dv = 1'b0;
    endtask

    // Idle cycles with garbage on the byte inputs
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        dv    = 1'b0;
        cmd   = '0;
        val   = '0;
        model_clear();

        // reset values
        idle(3);
        rst_n = 1'b1;
        idle(3);

        // single response, bit timing and completion pulse
        step(1'b1, c_CMD_TEMPERATURA, 8'h1A);
        idle(100);

        // second response queued during the first byte
        step(1'b1, c_CMD_TEMPERATURA, 8'h21);
        idle(10);
        step(1'b1, c_CMD_UMIDADE, 8'h37);
        idle(200);

        // third pulse in one transfer is dropped, overflow sticks
        step(1'b1, c_CMD_TEMPERATURA, 8'h19);
        idle(5);
        step(1'b1, c_CMD_UMIDADE, 8'h40);
        idle(5);
        step(1'b1, c_CMD_FALHA, 8'h1F);
        idle(200);

        // asynchronous reset during the value byte's data bits
        step(1'b1, c_CMD_ERRO, 8'hC3);
        idle(55);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rst_tx_g0",  bus0.tx,              1'b1);
        check("rst_oc_g0",  bus0.ocupado,         1'b0);
        check("rst_dn_g0",  bus0.envio_concluido, 1'b0);
        check("rst_ovf_g0", bus0.overflow,        1'b0);
        check("rst_tx_g2",  bus1.tx,              1'b1);
        check("rst_ovf_g2", bus1.overflow,        1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, c_CMD_OK, 8'h07);
        idle(100);

        // pulse in the DONE cycle with nothing pending
        step(1'b1, c_CMD_TEMPERATURA, 8'h5A);
        idle(FRAME);
        step(1'b1, c_CMD_UMIDADE, 8'hA5);
        idle(200);

        // two back-to-back queued responses (gap visible on the second DUT)
        step(1'b1, c_CMD_UMIDADE, 8'h11);
        step(1'b1, c_CMD_TEMPERATURA, 8'h22);
        idle(250);

        // random traffic, including overflow and DONE-cycle collisions
        for (int r = 0; r < 40; r++) begin
            idle($urandom_range(0, 120));
            step(1'b1, 8'($urandom), 8'($urandom));
        end
        idle(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
